// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode seven-segment driver.
// Frame-stable shadow of digit data, with leading-zero and blink blanking.
module seven_seg_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64,
  parameter bit HEX          = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    blank_lz,
  output logic [7:0]              seven_seg,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_tick
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] P_TC = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] B_TC = BW'(BLINK_FRAMES - 1);

  logic [PW-1:0]             r_presc;
  logic [IW-1:0]             r_idx;
  logic [BW-1:0]             r_bcnt;
  logic                      r_phase;
  logic                      r_pend;
  logic [4*NUM_DIGITS-1:0]   r_sh_dig;
  logic [NUM_DIGITS-1:0]     r_sh_dp;
  logic [NUM_DIGITS-1:0]     r_sh_bm;
  logic                      r_sh_lz;

  logic [4*NUM_DIGITS-1:0]   w_dig_all;
  logic [NUM_DIGITS-1:0]     w_dp_all;
  logic [NUM_DIGITS-1:0]     w_bm_all;
  logic                      w_lz_en;
  logic [3:0]                w_dig;
  logic                      w_dp;
  logic                      w_bm;
  logic                      w_zrun;
  logic                      w_lzb;
  logic [NUM_DIGITS-1:0]     w_an;
  logic [7:0]                w_dec;
  logic [7:0]                w_seg;
  logic                      w_tc;
  logic                      w_wrap;

  function automatic logic [7:0] dec7(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = HEX ? 8'h88 : 8'hFF;
      4'hB: s = HEX ? 8'h83 : 8'hFF;
      4'hC: s = HEX ? 8'hC6 : 8'hFF;
      4'hD: s = HEX ? 8'hA1 : 8'hFF;
      4'hE: s = HEX ? 8'h86 : 8'hFF;
      default: s = HEX ? 8'h8E : 8'hFF;
    endcase
    return s;
  endfunction

  // A pending post-reset load displays the incoming data straight away.
  assign w_dig_all = r_pend ? digits     : r_sh_dig;
  assign w_dp_all  = r_pend ? dp_mask    : r_sh_dp;
  assign w_bm_all  = r_pend ? blink_mask : r_sh_bm;
  assign w_lz_en   = r_pend ? blank_lz   : r_sh_lz;

  assign w_tc   = (r_presc == P_TC);
  assign w_wrap = w_tc && (r_idx == I_LAST);

  always_comb begin
    w_dig  = 4'd0;
    w_dp   = 1'b0;
    w_bm   = 1'b0;
    w_zrun = 1'b1;
    w_lzb  = 1'b0;
    w_an   = '1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zrun = w_zrun & (w_dig_all[4*i +: 4] == 4'd0);
      if (r_idx == IW'(i)) begin
        w_dig   = w_dig_all[4*i +: 4];
        w_dp    = w_dp_all[i];
        w_bm    = w_bm_all[i];
        w_an[i] = 1'b0;
        w_lzb   = (i > 0) && w_zrun;
      end
    end
    w_dec = dec7(w_dig);
    w_seg = {w_dec[7] & ~w_dp, w_dec[6:0]};
    if ((w_lz_en && w_lzb) || (r_phase && w_bm))
      w_seg = 8'hFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc    <= '0;
      r_idx      <= '0;
      r_bcnt     <= '0;
      r_phase    <= 1'b0;
      r_pend     <= 1'b1;
      r_sh_dig   <= '0;
      r_sh_dp    <= '0;
      r_sh_bm    <= '0;
      r_sh_lz    <= 1'b0;
      anode      <= '1;
      seven_seg  <= 8'hFF;
      frame_tick <= 1'b0;
    end else if (!en) begin
      anode      <= '1;
      seven_seg  <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      anode      <= w_an;
      seven_seg  <= w_seg;
      frame_tick <= w_wrap;
      if (w_tc) begin
        r_presc <= '0;
        r_idx   <= (r_idx == I_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
      if (w_wrap) begin
        if (r_bcnt == B_TC) begin
          r_bcnt  <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_bcnt <= r_bcnt + 1'b1;
        end
      end
      if (w_wrap || r_pend) begin
        r_sh_dig <= digits;
        r_sh_dp  <= dp_mask;
        r_sh_bm  <= blink_mask;
        r_sh_lz  <= blank_lz;
        r_pend   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Random and directed bench for seven_seg_scan against a time-based model.
// Two instances (HEX=0 and HEX=1) share every input.
module tb_seven_seg_scan;

  localparam int N  = 4;
  localparam int RD = 4;
  localparam int BF = 2;
  localparam int FR = N * RD;

  localparam logic [7:0] TBL [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [15:0]  digits;
  logic [3:0]   dpm;
  logic [3:0]   bm;
  logic         lz;
  logic [7:0]   seg0, seg1;
  logic [3:0]   an0, an1;
  logic         ft0, ft1;

  int n_vec = 0;
  int n_err = 0;

  // Model state: t counts enabled cycles since reset.
  int          t;
  logic [15:0] m_dig;
  logic [3:0]  m_dp, m_bm;
  logic        m_lz;
  bit          m_pend;
  logic [7:0]  e_seg0, e_seg1;
  logic [3:0]  e_an;
  logic        e_ft;

  always #5 clk = ~clk;

  seven_seg_scan #(
    .NUM_DIGITS(N), .REFRESH_DIV(RD), .BLINK_FRAMES(BF), .HEX(1'b0)
  ) u_dec (
    .clk(clk), .rst(rst), .en(en), .digits(digits),
    .dp_mask(dpm), .blink_mask(bm), .blank_lz(lz),
    .seven_seg(seg0), .anode(an0), .frame_tick(ft0)
  );

  seven_seg_scan #(
    .NUM_DIGITS(N), .REFRESH_DIV(RD), .BLINK_FRAMES(BF), .HEX(1'b1)
  ) u_hex (
    .clk(clk), .rst(rst), .en(en), .digits(digits),
    .dp_mask(dpm), .blink_mask(bm), .blank_lz(lz),
    .seven_seg(seg1), .anode(an1), .frame_tick(ft1)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_seg(
    input logic [15:0] dg, input logic [3:0] dp, input logic [3:0] bmk,
    input logic lzv, input int idx, input int phase, input bit hex);
    logic [7:0] s;
    logic [3:0] v;
    bit lead;
    v = dg[4*idx +: 4];
    lead = 1'b1;
    for (int j = idx; j < N; j++)
      if (dg[4*j +: 4] != 4'd0) lead = 1'b0;
    if (lzv && idx > 0 && lead) return 8'hFF;
    if (phase != 0 && bmk[idx]) return 8'hFF;
    s = (v >= 4'd10 && !hex) ? 8'hFF : TBL[v];
    if (dp[idx]) s[7] = 1'b0;
    return s;
  endfunction

  task automatic model_edge();
    int idx, ph;
    logic [15:0] dg;
    logic [3:0] dp, bk;
    logic lzv;
    if (rst) begin
      t = 0; m_dig = '0; m_dp = '0; m_bm = '0; m_lz = 1'b0;
      m_pend = 1'b1;
      e_an = 4'hF; e_seg0 = 8'hFF; e_seg1 = 8'hFF; e_ft = 1'b0;
    end else if (!en) begin
      e_an = 4'hF; e_seg0 = 8'hFF; e_seg1 = 8'hFF; e_ft = 1'b0;
    end else begin
      dg  = m_pend ? digits : m_dig;
      dp  = m_pend ? dpm : m_dp;
      bk  = m_pend ? bm : m_bm;
      lzv = m_pend ? lz : m_lz;
      idx = (t / RD) % N;
      ph  = ((t / FR) / BF) % 2;
      e_an   = ~(4'b0001 << idx);
      e_seg0 = ref_seg(dg, dp, bk, lzv, idx, ph, 1'b0);
      e_seg1 = ref_seg(dg, dp, bk, lzv, idx, ph, 1'b1);
      e_ft   = ((t % FR) == FR - 1);
      if (m_pend || e_ft) begin
        m_dig = digits; m_dp = dpm; m_bm = bm; m_lz = lz;
        m_pend = 1'b0;
      end
      t++;
    end
  endtask

  task automatic cyc(input logic r, input logic e);
    rst = r;
    en  = e;
    @(posedge clk);
    model_edge();
    #1;
    chk("anode",      {28'd0, an0}, {28'd0, e_an});
    chk("anode_hex",  {28'd0, an1}, {28'd0, e_an});
    chk("seg_dec",    {24'd0, seg0}, {24'd0, e_seg0});
    chk("seg_hex",    {24'd0, seg1}, {24'd0, e_seg1});
    chk("frame_tick", {31'd0, ft0}, {31'd0, e_ft});
  endtask

  initial begin
    logic [15:0] msk;
    rst = 1'b1; en = 1'b0;
    digits = 16'h1234; dpm = '0; bm = '0; lz = 1'b0;
    t = 0; m_pend = 1'b1;
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    repeat (3 * FR) cyc(1'b0, 1'b1);

    digits = 16'h0070; lz = 1'b1;
    repeat (2 * FR) cyc(1'b0, 1'b1);
    digits = 16'h0000;
    repeat (2 * FR) cyc(1'b0, 1'b1);

    digits = 16'h00B8; dpm = 4'b0001; lz = 1'b0;
    repeat (2 * FR) cyc(1'b0, 1'b1);

    digits = 16'h1234; dpm = '0;
    repeat (FR + RD + 1) cyc(1'b0, 1'b1);
    digits = 16'h5678;
    repeat (2 * FR) cyc(1'b0, 1'b1);

    bm = 4'b1000;
    repeat (6 * FR) cyc(1'b0, 1'b1);
    bm = '0;

    for (int k = 0; k < FR && ((t / RD) % N) != 2; k++)
      cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    repeat (10) cyc(1'b0, 1'b0);
    repeat (FR + 4) cyc(1'b0, 1'b1);

    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(3))
          0: msk = 16'hFFFF;
          1: msk = 16'h00FF;
          2: msk = 16'h000F;
          default: msk = 16'h0000;
        endcase
        digits = 16'($urandom) & msk;
        dpm = 4'($urandom);
        bm  = 4'($urandom);
        lz  = 1'($urandom);
      end
      cyc(1'($urandom_range(199) == 0), 1'($urandom_range(7) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
